pc_redirect_arbiter: RTL and testbench
======================================

# pc_redirect_arbiter

Sequencer and arbiter for the program-counter datapath (`pc_control`). It drives that block's `Selector` and `in_pc` inputs every cycle. It shares the single PC load path among several redirect requesters (exception, branch, jump, interrupt) using fixed priority and a valid/ready handshake. After each redirect it holds the PC for a programmable flush window, so downstream stages can discard wrong-path instructions.

## Interface
- `NUM_REQ`, default 4: number of redirect requesters, 1..8. Index 0 has the highest priority.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high per redirect, 1..15.
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded on the first cycle after reset.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  pipeline stall; holds the PC and blocks grants while in RUN.
- `req_valid`  in  NUM_REQ  redirect request per requester.
- `req_target`  in  NUM_REQ*32  target PC; requester i uses bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  grant, one-hot or zero, combinational.
- `Selector`  out  5  PC operation to `pc_control`, registered.
- `in_pc`  out  32  load value to `pc_control`, registered.
- `flush`  out  1  wrong-path flush, registered.
- `busy`  out  1  high whenever the state is not RUN, combinational from state.

## Operation
- `Selector` encoding:
  - 5'd0 HOLD
  - 5'd1 INC (PC+4)
  - 5'd2 LOAD (take `in_pc`)
  - all other codes are never driven.
- States: BOOT, RUN, FLUSH. Internal flush counter `cnt` is 4 bits.
- Reset, asynchronous:
  - state=BOOT, `cnt`=0
  - `Selector`=HOLD, `in_pc`=0, `flush`=0
  - `busy`=1, `req_ready`=0.
- BOOT, first edge after `rst` falls: `Selector`<=LOAD, `in_pc`<=RESET_VECTOR, go to RUN. `stall` is ignored in BOOT.
- Grant generation:
  - `g` = lowest-index set bit of `req_valid`.
  - In RUN: `req_ready` = `g` when `stall`=0, else 0.
  - In FLUSH: `req_ready[0]` = `req_valid[0]` (preemption, not gated by `stall`); all other bits are 0.
  - In BOOT: `req_ready` = 0.
- Accept = `req_valid[i] & req_ready[i]`. On the accept edge:
  - `Selector`<=LOAD, `in_pc`<=`req_target[i]`
  - `flush`<=1, `cnt`<=FLUSH_CYCLES, state<=FLUSH.
- RUN with no accept: `Selector`<= `stall` ? HOLD : INC. `in_pc` and `flush` (0) hold.
- FLUSH with no accept:
  - `Selector`<=HOLD, `cnt`<=`cnt`-1.
  - When `cnt`==1 at the edge: state<=RUN, `flush`<=0, `Selector`<= `stall` ? HOLD : INC.
  - `cnt` decrements regardless of `stall`.
- Preemption: an index-0 accept in FLUSH reloads exactly as a RUN accept does, restarting `cnt` at FLUSH_CYCLES.
- Requesters must hold `req_valid` and `req_target` stable until accepted. An un-granted request is not lost; it waits.

## Timing
- Accept at edge T:
  - T+1: `Selector`=LOAD, `in_pc`=target, `flush`=1.
  - T+2 .. T+FLUSH_CYCLES: `Selector`=HOLD, `flush`=1.
  - From T+FLUSH_CYCLES+1: `flush`=0, `Selector`=INC (or HOLD if stalled), state RUN.
- `flush` is therefore high for exactly FLUSH_CYCLES cycles per redirect. With FLUSH_CYCLES=1, only the LOAD cycle carries `flush`.
- Earliest next non-preempting grant is combinational in the first RUN cycle, i.e. the cycle starting at T+FLUSH_CYCLES+1.
- Simultaneous requests: only the lowest index is granted per accept. Higher indices are serviced in later RUN cycles.
- `stall` and a pending request in the same RUN cycle: no grant, `Selector`=HOLD.
- `rst` asserted mid-FLUSH: immediate return to reset values. The redirect is abandoned; BOOT reloads RESET_VECTOR.
- Latency `req_valid` to LOAD on `Selector`: 1 cycle when unblocked.

## Test plan
- Reset: hold `rst`=1 for 3 ns, release.
  - During reset: `Selector`=0, `in_pc`=0, `flush`=0, `busy`=1.
  - Next edge: `Selector`=2, `in_pc`=RESET_VECTOR.
  - Following edges: `Selector`=1, `busy`=0.
- Single redirect, FLUSH_CYCLES=2: `req_valid`=4'b0100, target 32'h0000_0100 for one cycle.
  - `req_ready`=4'b0100.
  - Next cycle: `Selector`=2, `in_pc`=32'h100, `flush`=1.
  - Then `Selector`=0, `flush`=1.
  - Then `Selector`=1, `flush`=0.
- Contention: `req_valid`=4'b1010 with targets 0x200 (idx1) and 0x300 (idx3), held.
  - idx1 granted first; `in_pc`=0x200.
  - idx3 `req_ready`=0 throughout FLUSH.
  - idx3 granted in the first RUN cycle; `in_pc`=0x300.
- Stall: `stall`=1 in RUN with `req_valid`=4'b0001.
  - `req_ready`=0 and `Selector`=0 every cycle.
  - Drop `stall`: grant, then `Selector`=2.
- Preemption: during the FLUSH for idx2 (0x100), assert idx0 with 0x8000_0000.
  - Immediate grant; `Selector`=2, `in_pc`=0x8000_0000.
  - `flush` stays high for a fresh 2 cycles.
- Reset mid-flush: assert `rst` in the second FLUSH cycle.
  - Outputs go to reset values without waiting for an edge.
  - After release: BOOT reload of RESET_VECTOR; no stale `flush`.

Source files
------------

// File: rtl/pc_redirect_arbiter_if.sv
// Redirect bus between the requesters / pipeline control and the PC arbiter.
interface pc_redirect_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                    stall;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*32-1:0]   req_target;
  logic [NUM_REQ-1:0]      req_ready;
  logic [4:0]              Selector;
  logic [31:0]             in_pc;
  logic                    flush;
  logic                    busy;

  // Requester / pipeline side.
  modport master (
    output stall, req_valid, req_target,
    input  req_ready, Selector, in_pc, flush, busy
  );

  // Arbiter side.
  modport slave (
    input  stall, req_valid, req_target,
    output req_ready, Selector, in_pc, flush, busy
  );
endinterface

// File: rtl/pc_redirect_arbiter.sv
// Fixed-priority redirect arbiter and PC sequencer for pc_control.
// Index 0 wins; it alone may preempt an ongoing flush window.

// One requester slot: granted when enabled, valid and no higher-priority
// requester is pending.
module pc_redirect_lane (
  input  logic valid,
  input  logic hi,
  input  logic en,
  output logic ready
);
  assign ready = en & valid & ~hi;
endmodule

module pc_redirect_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_redirect_arbiter_if.slave  bus
);
  localparam logic [4:0] SEL_HOLD = 5'd0;
  localparam logic [4:0] SEL_INC  = 5'd1;
  localparam logic [4:0] SEL_LOAD = 5'd2;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic [4:0]              sel, sel_n;
  logic [31:0]             pc, pc_n;
  logic                    fl, fl_n;

  logic [NUM_REQ-1:0][31:0] tgt;
  logic [NUM_REQ-1:0]       hi;
  logic [NUM_REQ-1:0]       ready;
  logic                     run_en, pre_en, accept;
  logic [31:0]              acc_target;

  assign tgt    = bus.req_target;
  // Normal grants need RUN and no stall; index 0 may also cut into FLUSH.
  assign run_en = (state == RUN) & ~bus.stall;
  assign pre_en = (state == FLUSH);

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      if (i == 0) begin : g_top
        assign hi[i] = 1'b0;
        pc_redirect_lane u_lane (
          .valid (bus.req_valid[i]),
          .hi    (hi[i]),
          .en    (run_en | pre_en),
          .ready (ready[i])
        );
      end else begin : g_rest
        assign hi[i] = hi[i-1] | bus.req_valid[i-1];
        pc_redirect_lane u_lane (
          .valid (bus.req_valid[i]),
          .hi    (hi[i]),
          .en    (run_en),
          .ready (ready[i])
        );
      end
    end
  endgenerate

  assign bus.req_ready = ready;
  assign accept        = |(bus.req_valid & ready);

  // Target of the (at most one) granted requester.
  always_comb begin
    acc_target = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (ready[k]) acc_target = tgt[k];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    pc_n    = pc;
    fl_n    = fl;
    case (state)
      BOOT: begin
        sel_n   = SEL_LOAD;
        pc_n    = RESET_VECTOR;
        state_n = RUN;
      end
      RUN, FLUSH: begin
        if (accept) begin
          sel_n   = SEL_LOAD;
          pc_n    = acc_target;
          fl_n    = 1'b1;
          cnt_n   = 4'(FLUSH_CYCLES);
          state_n = FLUSH;
        end else if (state == RUN) begin
          sel_n = bus.stall ? SEL_HOLD : SEL_INC;
        end else begin
          // Window counts down even while stalled.
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n = RUN;
            fl_n    = 1'b0;
            sel_n   = bus.stall ? SEL_HOLD : SEL_INC;
          end else begin
            sel_n = SEL_HOLD;
          end
        end
      end
      default: state_n = BOOT;
    endcase
  end

  // State and output registers; reset abandons any redirect in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      cnt   <= 4'd0;
      sel   <= SEL_HOLD;
      pc    <= 32'd0;
      fl    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      pc    <= pc_n;
      fl    <= fl_n;
    end
  end

  assign bus.Selector = sel;
  assign bus.in_pc    = pc;
  assign bus.flush    = fl;
  assign bus.busy     = (state != RUN);
endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Directed table-driven bench for pc_redirect_arbiter (NUM_REQ=4, FLUSH_CYCLES=2).
module tb_pc_redirect_arbiter;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_redirect_arbiter_if #(.NUM_REQ(4)) bus ();

  pc_redirect_arbiter #(
    .NUM_REQ(4), .FLUSH_CYCLES(2), .RESET_VECTOR(RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic             stall;
    logic [3:0]       valid;
    logic [3:0][31:0] tgt;
    logic [3:0]       ready;  // combinational, before the edge
    logic [4:0]       sel;    // registered, after the edge
    logic [31:0]      pc;
    logic             fl;
    logic             bsy;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[25];

  function automatic vec_t mk(logic s, logic [3:0] v, logic [31:0] t3, logic [31:0] t2,
                              logic [31:0] t1, logic [31:0] t0, logic [3:0] r,
                              logic [4:0] se, logic [31:0] p, logic f, logic b);
    vec_t x;
    x.stall = s; x.valid = v;
    x.tgt[3] = t3; x.tgt[2] = t2; x.tgt[1] = t1; x.tgt[0] = t0;
    x.ready = r; x.sel = se; x.pc = p; x.fl = f; x.bsy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [4:0] se, input logic [31:0] p,
                          input logic f, input logic b);
    chk({tag, ".sel"},   32'(bus.Selector), 32'(se));
    chk({tag, ".in_pc"}, bus.in_pc, p);
    chk({tag, ".flush"}, 32'(bus.flush), 32'(f));
    chk({tag, ".busy"},  32'(bus.busy), 32'(b));
  endtask

  initial begin
    //            stall valid   t3     t2            t1     t0            ready   sel  pc            fl  busy
    // single redirect idx2
    tbl[0]  = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 1, RV,           0, 0);
    tbl[1]  = mk(0, 4'b0100, 0,     32'h100,      0,     0,            4'b0100, 2, 32'h100,      1, 1);
    tbl[2]  = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 0, 32'h100,      1, 1);
    tbl[3]  = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 1, 32'h100,      0, 0);
    // contention idx1 vs idx3
    tbl[4]  = mk(0, 4'b1010, 32'h300, 0,          32'h200, 0,          4'b0010, 2, 32'h200,      1, 1);
    tbl[5]  = mk(0, 4'b1000, 32'h300, 0,          0,     0,            4'b0000, 0, 32'h200,      1, 1);
    tbl[6]  = mk(0, 4'b1000, 32'h300, 0,          0,     0,            4'b0000, 1, 32'h200,      0, 0);
    tbl[7]  = mk(0, 4'b1000, 32'h300, 0,          0,     0,            4'b1000, 2, 32'h300,      1, 1);
    tbl[8]  = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 0, 32'h300,      1, 1);
    tbl[9]  = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 1, 32'h300,      0, 0);
    // stall blocks grant; flush window counts through stall; exit to HOLD
    tbl[10] = mk(1, 4'b0001, 0,     0,            0,     32'h400,      4'b0000, 0, 32'h300,      0, 0);
    tbl[11] = mk(1, 4'b0001, 0,     0,            0,     32'h400,      4'b0000, 0, 32'h300,      0, 0);
    tbl[12] = mk(0, 4'b0001, 0,     0,            0,     32'h400,      4'b0001, 2, 32'h400,      1, 1);
    tbl[13] = mk(1, 4'b0000, 0,     0,            0,     0,            4'b0000, 0, 32'h400,      1, 1);
    tbl[14] = mk(1, 4'b0000, 0,     0,            0,     0,            4'b0000, 0, 32'h400,      0, 0);
    tbl[15] = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 1, 32'h400,      0, 0);
    // preemption by idx0 during idx2 flush, with stall high
    tbl[16] = mk(0, 4'b0100, 0,     32'h100,      0,     0,            4'b0100, 2, 32'h100,      1, 1);
    tbl[17] = mk(1, 4'b0001, 0,     0,            0,     32'h8000_0000, 4'b0001, 2, 32'h8000_0000, 1, 1);
    tbl[18] = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 0, 32'h8000_0000, 1, 1);
    tbl[19] = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 1, 32'h8000_0000, 0, 0);
    // idx0 and idx2 together; idx2 may not preempt
    tbl[20] = mk(0, 4'b0101, 0,     32'h600,      0,     32'h500,      4'b0001, 2, 32'h500,      1, 1);
    tbl[21] = mk(0, 4'b0100, 0,     32'h600,      0,     0,            4'b0000, 0, 32'h500,      1, 1);
    tbl[22] = mk(0, 4'b0100, 0,     32'h600,      0,     0,            4'b0000, 1, 32'h500,      0, 0);
    tbl[23] = mk(0, 4'b0100, 0,     32'h600,      0,     0,            4'b0100, 2, 32'h600,      1, 1);
    tbl[24] = mk(0, 4'b0000, 0,     0,            0,     0,            4'b0000, 0, 32'h600,      1, 1);

    // Reset phase: rst high for 3 ns, a request pending that BOOT must not grant.
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_target = '0;
    #1;
    chk_regs("reset", 5'd0, 32'd0, 1'b0, 1'b1);
    chk("reset.ready", 32'(bus.req_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("boot.ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    chk_regs("boot", 5'd2, RV, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      bus.stall      = tbl[i].stall;
      bus.req_valid  = tbl[i].valid;
      bus.req_target = tbl[i].tgt;
      #1;
      chk($sformatf("row%0d.ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      @(posedge clk); #1;
      chk_regs($sformatf("row%0d", i), tbl[i].sel, tbl[i].pc, tbl[i].fl, tbl[i].bsy);
    end

    // Reset in the second flush cycle: outputs clear without a clock edge.
    bus.req_valid = 4'b0001;
    bus.req_target = '0;
    #2 rst = 1'b1;
    #1;
    chk_regs("midrst", 5'd0, 32'd0, 1'b0, 1'b1);
    chk("midrst.ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    chk_regs("midrst.held", 5'd0, 32'd0, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_regs("reboot", 5'd2, RV, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_regs("reboot.run", 5'd1, RV, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
